// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide engine: single-step 32x32 multiply and a
// 32-iteration restoring divider, producing a 64-bit HI/LO result.
module muldiv_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [7:0]  MULT_OP  = 8'b00011000,
  parameter logic [7:0]  MULTU_OP = 8'b00011001,
  parameter logic [7:0]  DIV_OP   = 8'b00011010,
  parameter logic [7:0]  DIVU_OP  = 8'b00011011
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall_o,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = 5;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_ON, S_DIV_ZERO, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;        // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] prev_hi_q, prev_hi_d, prev_lo_q, prev_lo_d;

  logic             is_mul, is_div, is_signed;
  logic signed [WIDTH:0]  mul_a, mul_b;
  logic signed [PW-1:0]   prod;
  logic [WIDTH:0]         rem_sh, diff;
  logic                   ge;
  logic [WIDTH-1:0]       rem_nx, quo_nx;

  // Operand datapath: product and one restoring-division step.
  always_comb begin
    is_mul    = (alucontrol == MULT_OP) || (alucontrol == MULTU_OP);
    is_div    = (alucontrol == DIV_OP)  || (alucontrol == DIVU_OP);
    is_signed = (alucontrol == MULT_OP) || (alucontrol == DIV_OP);
    mul_a     = $signed({sgn_q & a_q[WIDTH-1], a_q});
    mul_b     = $signed({sgn_q & b_q[WIDTH-1], b_q});
    prod      = PW'(mul_a) * PW'(mul_b);
    rem_sh    = {rem_q, a_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, b_q};
    ge        = ~diff[WIDTH];
    rem_nx    = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx    = {a_q[WIDTH-2:0], ge};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    sgn_d     = sgn_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prev_hi_d = prev_hi_q;
    prev_lo_d = prev_lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (valid_i && is_mul) begin
          a_d     = src_a;
          b_d     = src_b;
          sgn_d   = is_signed;
          state_d = S_MUL;
        end else if (valid_i && is_div) begin
          if (src_b == '0) begin
            state_d = S_DIV_ZERO;
          end else begin
            a_d     = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
            b_d     = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            rneg_d  = is_signed & src_a[WIDTH-1];
            state_d = S_DIV_ON;
          end
        end
      end
      S_MUL: begin
        prev_hi_d    = hi_q;
        prev_lo_d    = lo_q;
        {hi_d, lo_d} = prod;
        state_d      = S_DONE;
      end
      S_DIV_ON: begin
        a_d   = quo_nx;
        rem_d = rem_nx;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          prev_hi_d = hi_q;
          prev_lo_d = lo_q;
          lo_d      = qneg_q ? -quo_nx : quo_nx;
          hi_d      = rneg_q ? -rem_nx : rem_nx;
          state_d   = S_DONE;
        end
      end
      S_DIV_ZERO: begin
        prev_hi_d = hi_q;
        prev_lo_d = lo_q;
        hi_d      = '0;
        lo_d      = '0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A flush cancels the operation; a result already staged in DONE is rolled back.
    if (flush) begin
      state_d = S_IDLE;
      if (state_q == S_DONE) begin
        hi_d = prev_hi_q;
        lo_d = prev_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      sgn_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      prev_hi_q <= '0;
      prev_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      sgn_q     <= sgn_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prev_hi_q <= prev_hi_d;
      prev_lo_q <= prev_lo_d;
    end
  end

  // Pipeline handshake is combinational so the acceptance cycle stalls too.
  assign stall_o = (state_q == S_MUL) || (state_q == S_DIV_ON) || (state_q == S_DIV_ZERO) ||
                   ((state_q == S_IDLE) && valid_i && (is_mul || is_div));
  assign result_valid = (state_q == S_DONE) && !flush;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus flush/reset sequences.
module tb_muldiv_unit;

  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_ADD   = 8'b00100000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  alucontrol;
  logic        valid_i;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        stall_o, result_valid;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .alucontrol   (alucontrol),
    .valid_i      (valid_i),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .stall_o      (stall_o),
    .result_valid (result_valid),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at posedge+1 and follow it to its result_valid pulse.
  task automatic run_op(input int idx, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int cyc;
    int stalls;
    alucontrol = op;
    src_a      = a;
    src_b      = b;
    valid_i    = 1'b1;
    #1;
    stalls = stall_o ? 1 : 0;
    @(posedge clk);
    #1;
    valid_i    = 1'b0;
    src_a      = $urandom;
    src_b      = $urandom;
    alucontrol = 8'($urandom);
    cyc = 1;
    while (!result_valid && cyc < 100) begin
      if (stall_o) stalls++;
      tick();
      cyc++;
    end
    check($sformatf("v%0d latency", idx), 64'(cyc), 64'(lat));
    check($sformatf("v%0d stall_cycles", idx), 64'(stalls), 64'(lat));
    check($sformatf("v%0d hi", idx), 64'(hi_o), 64'(eh));
    check($sformatf("v%0d lo", idx), 64'(lo_o), 64'(el));
    check($sformatf("v%0d stall_in_done", idx), 64'(stall_o), 64'(0));
    tick();
    check($sformatf("v%0d rv_one_cycle", idx), 64'(result_valid), 64'(0));
  endtask

  initial begin
    int rv_seen;
    int st_seen;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 2};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33};
    vecs[4]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000, 2};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[6]  = '{OP_MULT,  32'd6,        32'd7,        32'h00000000, 32'd42,       2};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33};
    vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
    vecs[10] = '{OP_DIV,   32'h00000000, 32'd5,        32'h00000000, 32'h00000000, 33};
    vecs[11] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 33};

    resetn = 1'b0; valid_i = 1'b0; flush = 1'b0;
    alucontrol = '0; src_a = '0; src_b = '0;
    #12;
    check("reset hi", 64'(hi_o), 64'(0));
    check("reset lo", 64'(lo_o), 64'(0));
    check("reset stall", 64'(stall_o), 64'(0));
    check("reset rv", 64'(result_valid), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Known prior result, then flush a divide on iteration 10.
    run_op(20, OP_MULTU, 32'hAAAA5555, 32'd1, 32'h00000000, 32'hAAAA5555, 2);
    alucontrol = OP_DIVU; src_a = 32'd100; src_b = 32'd7; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("flush stall_before", 64'(stall_o), 64'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush stall_after", 64'(stall_o), 64'(0));
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) rv_seen++;
      tick();
    end
    check("flush no_rv", 64'(rv_seen), 64'(0));
    check("flush hi_kept", 64'(hi_o), 64'(0));
    check("flush lo_kept", 64'(lo_o), 64'(32'hAAAA5555));
    run_op(21, OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 2);

    // Flush arriving in the DONE cycle suppresses and rolls back the result.
    alucontrol = OP_MULT; src_a = 32'd3; src_b = 32'd5; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    tick();
    check("done_flush rv_before", 64'(result_valid), 64'(1));
    flush = 1'b1;
    #1;
    check("done_flush rv_forced", 64'(result_valid), 64'(0));
    tick();
    flush = 1'b0;
    #1;
    check("done_flush lo_restored", 64'(lo_o), 64'(42));
    check("done_flush hi_restored", 64'(hi_o), 64'(0));
    check("done_flush rv_after", 64'(result_valid), 64'(0));

    // Flush on the acceptance cycle wins over acceptance.
    alucontrol = OP_DIV; src_a = 32'd9; src_b = 32'd3; valid_i = 1'b1; flush = 1'b1;
    tick();
    valid_i = 1'b0; flush = 1'b0;
    #1;
    check("idle_flush stall", 64'(stall_o), 64'(0));

    // Reset dropped mid-divide clears outputs without waiting for a clock edge.
    alucontrol = OP_DIVU; src_a = 32'd1000; src_b = 32'd3; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    #1;
    check("async_rst hi", 64'(hi_o), 64'(0));
    check("async_rst lo", 64'(lo_o), 64'(0));
    check("async_rst stall", 64'(stall_o), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (result_valid) rv_seen++;
    end
    check("async_rst no_rv", 64'(rv_seen), 64'(0));

    // Non-muldiv op and idle muldiv code never stall.
    alucontrol = OP_ADD; src_a = 32'd1; src_b = 32'd2; valid_i = 1'b1;
    st_seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (stall_o) st_seen++;
      tick();
    end
    check("add no_stall", 64'(st_seen), 64'(0));
    alucontrol = OP_MULT; valid_i = 1'b0;
    #1;
    check("invalid no_stall", 64'(stall_o), 64'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
